// File: rtl/stage_issue_ctl.sv
// Issue-stage controller: emit/bubble/hold with a configurable jump shadow and flush.
// Define STAGE_SKID_EN to add a 1-entry skid buffer that registers the upstream stall.
module stage_issue_ctl #(
   parameter int WIDTH  = 32,
   parameter int SHADOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_pred,
   input  logic             in_jump,
   input  logic             in_hazard,
   input  logic             flush,
   input  logic             stall_in,
   output logic             stall,
   output logic             discard,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_jump
);
   localparam logic [3:0] SHD_LOAD = 4'(SHADOW);

   logic [3:0] shd, next_shd;
   logic       emit, advance;

`ifdef STAGE_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_jump;

   // Downstream stall only reaches upstream through the registered skid_valid.
   assign stall   = skid_valid | ~in_valid | in_hazard;
   assign advance = ~skid_valid;
`else
   assign stall   = stall_in | ~in_valid | in_hazard;
   assign advance = ~stall_in;
`endif

   assign emit = ~stall & (shd == 4'd0) & in_pred;

   always_comb begin
      next_shd = shd;
      if (emit && in_jump)
         next_shd = SHD_LOAD;
      else if (advance && shd != 4'd0)
         next_shd = shd - 4'd1;
   end

   assign discard = (next_shd != 4'd0);

`ifdef STAGE_SKID_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_jump   <= 1'b0;
         shd        <= 4'd0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_jump  <= 1'b0;
      end else begin
         shd <= next_shd;
         if (!stall_in) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_jump   <= skid_jump;
               skid_valid <= 1'b0;
            end else if (emit) begin
               out_valid <= 1'b1;
               out_data  <= in_data;
               out_jump  <= in_jump;
            end else begin
               out_valid <= 1'b0;
               out_data  <= '0;
               out_jump  <= 1'b0;
            end
         end else if (emit) begin
            // Output slot is free only if it holds a bubble; otherwise park in the skid.
            if (!out_valid) begin
               out_valid <= 1'b1;
               out_data  <= in_data;
               out_jump  <= in_jump;
            end else begin
               skid_valid <= 1'b1;
               skid_data  <= in_data;
               skid_jump  <= in_jump;
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_jump  <= 1'b0;
         shd       <= 4'd0;
      end else begin
         shd <= next_shd;
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_jump  <= in_jump;
         end else if (!stall_in) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_jump  <= 1'b0;
         end
      end
   end
`endif

endmodule
